// File: rtl/unary_ctrl_pkg.sv
// Shared types for the unary-stream counter sequencer: FSM state encoding
// and the {valid,last,final} marker that travels alongside counter values.
package unary_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 'final' is a reserved word, so the final-epoch flag is named fin.
  typedef struct packed {
    logic valid;
    logic last;
    logic fin;
  } marker_t;

  localparam marker_t MARKER_NONE = '{valid: 1'b0, last: 1'b0, fin: 1'b0};

endpackage

// File: rtl/unary_marker_delay.sv
// BUF_LAT-deep marker shift register matching the counter output buffering;
// flush empties every stage on the next edge.
module unary_marker_delay
  import unary_ctrl_pkg::*;
#(
  parameter int BUF_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  marker_t din,
  output marker_t dout
);

  generate
    if (BUF_LAT == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      marker_t stage_reg [BUF_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < BUF_LAT; i++) stage_reg[i] <= MARKER_NONE;
        end else if (flush) begin
          for (int i = 0; i < BUF_LAT; i++) stage_reg[i] <= MARKER_NONE;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < BUF_LAT; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[BUF_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/unary_epoch_ctrl.sv
// Job sequencer for the shared unary-stream counter: replays 0..len-1 per epoch,
// emits markers aligned to the buffered counter outputs, with halt and abort.
module unary_epoch_ctrl
  import unary_ctrl_pkg::*;
#(
  parameter int CWID    = 10,
  parameter int EWID    = 8,
  parameter int BUF_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [CWID-1:0] cfg_len_m1,
  input  logic [EWID-1:0] cfg_epochs_m1,
  input  logic            halt,
  input  logic            abort,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            data_valid,
  output logic            data_last,
  output logic            data_final,
  output logic [EWID-1:0] epoch_idx,
  output logic            busy,
  output logic            done,
  output logic            done_aborted
);

  localparam logic [2:0] DRAIN_LOAD = (BUF_LAT > 0) ? 3'(BUF_LAT - 1) : 3'd0;

  state_t          state_reg, state_next;
  logic [CWID-1:0] cyc_reg, cyc_next, len_reg, len_next;
  logic [EWID-1:0] epoch_reg, epoch_next, epochs_reg, epochs_next;
  logic [2:0]      drain_reg, drain_next;
  logic            aborting_reg, aborting_next;
  logic            cnt_en_reg, cnt_en_next, cnt_clr_reg, cnt_clr_next;
  logic            busy_reg, busy_next, ready_reg, ready_next;
  logic            done_reg, done_next, done_ab_reg, done_ab_next;
  marker_t         issue_reg, issue_next, data_mk;
  logic            abort_hit;

  // A second abort during the abort's own clear cycle is redundant.
  assign abort_hit = abort && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN) ||
                               ((state_reg == ST_CLEAR) && !aborting_reg));

  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    len_next      = len_reg;
    epoch_next    = epoch_reg;
    epochs_next   = epochs_reg;
    drain_next    = drain_reg;
    aborting_next = aborting_reg;
    cnt_en_next   = 1'b0;
    cnt_clr_next  = 1'b0;
    done_next     = 1'b0;
    done_ab_next  = 1'b0;
    issue_next    = MARKER_NONE;

    case (state_reg)
      ST_IDLE: begin
        if (start_valid && ready_reg) begin
          len_next      = cfg_len_m1;
          epochs_next   = cfg_epochs_m1;
          cyc_next      = '0;
          epoch_next    = '0;
          aborting_next = 1'b0;
          cnt_clr_next  = 1'b1;
          state_next    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (aborting_reg) begin
          done_next    = 1'b1;
          done_ab_next = 1'b1;
          state_next   = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!halt) begin
          issue_next.valid = 1'b1;
          if (cyc_reg == len_reg) begin
            // Restart via clear so a full-range length never relies on wrap.
            cnt_clr_next    = 1'b1;
            issue_next.last = 1'b1;
            if (epoch_reg < epochs_reg) begin
              cyc_next   = '0;
              epoch_next = epoch_reg + EWID'(1);
            end else begin
              issue_next.fin = 1'b1;
              if (BUF_LAT == 0) begin
                done_next  = 1'b1;
                state_next = ST_DONE;
              end else begin
                drain_next = DRAIN_LOAD;
                state_next = ST_DRAIN;
              end
            end
          end else begin
            cnt_en_next = 1'b1;
            cyc_next    = cyc_reg + CWID'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_reg == 3'd0) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else begin
          drain_next = drain_reg - 3'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (abort_hit) begin
      cyc_next      = cyc_reg;
      epoch_next    = epoch_reg;
      aborting_next = 1'b1;
      cnt_en_next   = 1'b0;
      cnt_clr_next  = 1'b1;
      done_next     = 1'b0;
      done_ab_next  = 1'b0;
      issue_next    = MARKER_NONE;
      state_next    = ST_CLEAR;
    end

    busy_next  = (state_next == ST_CLEAR) || (state_next == ST_RUN) || (state_next == ST_DRAIN);
    ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cyc_reg      <= '0;
      len_reg      <= '0;
      epoch_reg    <= '0;
      epochs_reg   <= '0;
      drain_reg    <= 3'd0;
      aborting_reg <= 1'b0;
      cnt_en_reg   <= 1'b0;
      cnt_clr_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      done_ab_reg  <= 1'b0;
      issue_reg    <= MARKER_NONE;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      len_reg      <= len_next;
      epoch_reg    <= epoch_next;
      epochs_reg   <= epochs_next;
      drain_reg    <= drain_next;
      aborting_reg <= aborting_next;
      cnt_en_reg   <= cnt_en_next;
      cnt_clr_reg  <= cnt_clr_next;
      busy_reg     <= busy_next;
      ready_reg    <= ready_next;
      done_reg     <= done_next;
      done_ab_reg  <= done_ab_next;
      issue_reg    <= issue_next;
    end
  end

  // issue_reg lines up with the counter register; the delay matches its buffering.
  unary_marker_delay #(.BUF_LAT(BUF_LAT)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort_hit),
    .din   (issue_reg),
    .dout  (data_mk)
  );

  assign start_ready  = ready_reg;
  assign cnt_en       = cnt_en_reg;
  assign cnt_clr      = cnt_clr_reg;
  assign data_valid   = data_mk.valid;
  assign data_last    = data_mk.last;
  assign data_final   = data_mk.fin;
  assign epoch_idx    = epoch_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign done_aborted = done_ab_reg;

endmodule

// File: tb/tb_unary_epoch_ctrl.sv
// Bench for unary_epoch_ctrl: two instances (BUF_LAT=1 and 0) share stimulus and
// are compared every cycle against a beat-schedule model, plus directed tables.
module tb_unary_epoch_ctrl;

  localparam int CWID = 4;
  localparam int EWID = 8;
  localparam int MAXW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_valid = 1'b0;
  logic            halt = 1'b0;
  logic            abort = 1'b0;
  logic [CWID-1:0] cfg_len_m1 = '0;
  logic [EWID-1:0] cfg_epochs_m1 = '0;

  logic            o_rdy [2], o_en [2], o_clr [2], o_v [2], o_l [2], o_f [2];
  logic            o_busy [2], o_done [2], o_ab [2];
  logic [EWID-1:0] o_ep [2];

  unary_epoch_ctrl #(.CWID(CWID), .EWID(EWID), .BUF_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(o_rdy[0]),
    .cfg_len_m1(cfg_len_m1), .cfg_epochs_m1(cfg_epochs_m1), .halt(halt), .abort(abort),
    .cnt_en(o_en[0]), .cnt_clr(o_clr[0]), .data_valid(o_v[0]), .data_last(o_l[0]),
    .data_final(o_f[0]), .epoch_idx(o_ep[0]), .busy(o_busy[0]), .done(o_done[0]),
    .done_aborted(o_ab[0]));

  unary_epoch_ctrl #(.CWID(CWID), .EWID(EWID), .BUF_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(o_rdy[1]),
    .cfg_len_m1(cfg_len_m1), .cfg_epochs_m1(cfg_epochs_m1), .halt(halt), .abort(abort),
    .cnt_en(o_en[1]), .cnt_clr(o_clr[1]), .data_valid(o_v[1]), .data_last(o_l[1]),
    .data_final(o_f[1]), .epoch_idx(o_ep[1]), .busy(o_busy[1]), .done(o_done[1]),
    .done_aborted(o_ab[1]));

  int checks = 0;
  int failures = 0;

  // Stimulus per cycle of a scenario window; cycle 0 carries the accepted start.
  bit s_halt [MAXW];
  bit s_abort [MAXW];
  bit s_sv [MAXW];

  // Expected outputs per instance per cycle (index 0: BUF_LAT=1, 1: BUF_LAT=0).
  bit e_rdy [2][MAXW], e_en [2][MAXW], e_clr [2][MAXW], e_v [2][MAXW], e_l [2][MAXW];
  bit e_f [2][MAXW], e_busy [2][MAXW], e_done [2][MAXW], e_ab [2][MAXW];
  int e_ep [2][MAXW];
  int done_c [2];
  int prev_epoch = 0;

  // Per-window measurements used by the directed table.
  int m_v, m_l, m_f, m_en, m_clr, m_ab;
  int m_done [2];

  task automatic chk(input string nm, input int bi, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s lat%0d cycle %0d: got %0d expected %0d", nm, (bi == 0) ? 1 : 0, c, act, exp);
    end
  endtask

  // Beat-level model: each non-halted RUN cycle is one beat of L*E; outputs of
  // a beat appear the next cycle, data markers BUF_LAT cycles later still.
  task automatic build_model(input int lm, input int em);
    int L, E, total, k, ep_cur, t, a, bl, n, pos, last_busy, dc;
    bit iv [MAXW];
    bit il [MAXW];
    bit ifn [MAXW];
    for (int bi = 0; bi < 2; bi++) begin
      bl = (bi == 0) ? 1 : 0;
      L = lm + 1; E = em + 1; total = L * E;
      k = 0; ep_cur = 0; t = -1; a = -1;
      for (int c = 0; c < MAXW; c++) begin
        e_rdy[bi][c] = 1; e_en[bi][c] = 0; e_clr[bi][c] = 0; e_v[bi][c] = 0;
        e_l[bi][c] = 0; e_f[bi][c] = 0; e_busy[bi][c] = 0; e_done[bi][c] = 0;
        e_ab[bi][c] = 0; e_ep[bi][c] = (c == 0) ? prev_epoch : 0;
        iv[c] = 0; il[c] = 0; ifn[c] = 0;
      end
      e_clr[bi][1] = 1;
      if (s_abort[1]) a = 1;
      n = 2;
      while (a < 0 && t < 0 && n < MAXW - 8) begin
        if (s_abort[n]) a = n;
        else if (!s_halt[n]) begin
          pos = k % L;
          e_en[bi][n+1]  = (pos != L - 1);
          e_clr[bi][n+1] = (pos == L - 1);
          iv[n+1] = 1; il[n+1] = (pos == L - 1); ifn[n+1] = (k == total - 1);
          if (pos == L - 1 && k != total - 1) begin
            ep_cur++;
            for (int m = n + 1; m < MAXW; m++) e_ep[bi][m] = ep_cur;
          end
          k++;
          if (k == total) t = n;
        end
        n++;
      end
      if (t >= 0) for (int d = t + 1; d <= t + bl; d++) if (a < 0 && s_abort[d]) a = d;
      if (a >= 0) begin
        last_busy = a + 1;
        e_clr[bi][a+1] = 1;
        dc = a + 2;
        e_ab[bi][dc] = 1;
      end else begin
        last_busy = t + bl;
        dc = t + bl + 1;
      end
      for (int c = 1; c <= last_busy; c++) e_busy[bi][c] = 1;
      for (int c = 1; c <= dc; c++) e_rdy[bi][c] = 0;
      e_done[bi][dc] = 1;
      for (int c = bl; c < MAXW; c++) begin
        if (a < 0 || c <= a) begin
          e_v[bi][c] = iv[c-bl]; e_l[bi][c] = il[c-bl]; e_f[bi][c] = ifn[c-bl];
        end
      end
      done_c[bi] = dc;
    end
    prev_epoch = ep_cur;
  endtask

  task automatic run_window(input int lm, input int em, input bit hold);
    int w, lim;
    build_model(lm, em);
    lim = (done_c[0] < done_c[1]) ? done_c[0] : done_c[1];
    for (int c = 0; c < MAXW; c++) s_sv[c] = (c == 0) || (hold && c <= lim && ($urandom_range(0, 1) == 1));
    w = ((done_c[0] > done_c[1]) ? done_c[0] : done_c[1]) + 3;
    m_v = 0; m_l = 0; m_f = 0; m_en = 0; m_clr = 0; m_ab = 0; m_done[0] = -1; m_done[1] = -1;
    for (int c = 0; c < w; c++) begin
      @(posedge clk); #1;
      start_valid   = s_sv[c];
      halt          = s_halt[c];
      abort         = s_abort[c];
      cfg_len_m1    = (c == 0) ? CWID'(lm) : CWID'($urandom);
      cfg_epochs_m1 = (c == 0) ? EWID'(em) : EWID'($urandom);
      @(negedge clk);
      for (int bi = 0; bi < 2; bi++) begin
        chk("start_ready", bi, c, int'(o_rdy[bi]), int'(e_rdy[bi][c]));
        chk("cnt_en", bi, c, int'(o_en[bi]), int'(e_en[bi][c]));
        chk("cnt_clr", bi, c, int'(o_clr[bi]), int'(e_clr[bi][c]));
        chk("data_valid", bi, c, int'(o_v[bi]), int'(e_v[bi][c]));
        chk("data_last", bi, c, int'(o_l[bi]), int'(e_l[bi][c]));
        chk("data_final", bi, c, int'(o_f[bi]), int'(e_f[bi][c]));
        chk("epoch_idx", bi, c, int'(o_ep[bi]), e_ep[bi][c]);
        chk("busy", bi, c, int'(o_busy[bi]), int'(e_busy[bi][c]));
        chk("done", bi, c, int'(o_done[bi]), int'(e_done[bi][c]));
        chk("done_aborted", bi, c, int'(o_ab[bi]), int'(e_ab[bi][c]));
        if (o_done[bi] && m_done[bi] < 0) m_done[bi] = c;
      end
      m_v += int'(o_v[0]); m_l += int'(o_l[0]); m_f += int'(o_f[0]);
      m_en += int'(o_en[0]); m_clr += int'(o_clr[0]); m_ab += int'(o_ab[0]);
    end
    start_valid = 0; halt = 0; abort = 0;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXW; c++) begin s_halt[c] = 0; s_abort[c] = 0; s_sv[c] = 0; end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int bi = 0; bi < 2; bi++) begin
      chk({tag, "_ready"}, bi, 0, int'(o_rdy[bi]), 1);
      chk({tag, "_en"}, bi, 0, int'(o_en[bi]), 0);
      chk({tag, "_clr"}, bi, 0, int'(o_clr[bi]), 0);
      chk({tag, "_valid"}, bi, 0, int'(o_v[bi]), 0);
      chk({tag, "_epoch"}, bi, 0, int'(o_ep[bi]), 0);
      chk({tag, "_busy"}, bi, 0, int'(o_busy[bi]), 0);
      chk({tag, "_done"}, bi, 0, int'(o_done[bi]), 0);
    end
  endtask

  typedef struct {
    int lm, em, halt_at, halt_len, abort_at;
    bit hold;
    int v, l, f, en, clr, d1, d0, ab;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lm, em, total;
    // Expected counts are for the BUF_LAT=1 instance; done cycles for both.
    tbl[0] = '{3, 1, 0, 0, 0, 0,  8, 2, 1,  6, 3, 11, 10, 0};
    tbl[1] = '{3, 1, 4, 3, 0, 0,  8, 2, 1,  6, 3, 14, 13, 0};
    tbl[2] = '{0, 4, 0, 0, 0, 0,  5, 5, 1,  0, 6,  8,  7, 0};
    tbl[3] = '{15, 0, 0, 0, 0, 0, 16, 1, 1, 15, 2, 19, 18, 0};
    tbl[4] = '{3, 1, 7, 1, 7, 0,  4, 1, 0,  4, 3,  9,  9, 1};
    tbl[5] = '{3, 1, 0, 0, 0, 1,  8, 2, 1,  6, 3, 11, 10, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      clear_stim();
      for (int h = 0; h < tbl[i].halt_len; h++) s_halt[tbl[i].halt_at + h] = 1;
      if (tbl[i].abort_at > 0) s_abort[tbl[i].abort_at] = 1;
      run_window(tbl[i].lm, tbl[i].em, tbl[i].hold);
      chk($sformatf("vec%0d_beats", i), 0, i, m_v, tbl[i].v);
      chk($sformatf("vec%0d_lasts", i), 0, i, m_l, tbl[i].l);
      chk($sformatf("vec%0d_finals", i), 0, i, m_f, tbl[i].f);
      chk($sformatf("vec%0d_cnt_en", i), 0, i, m_en, tbl[i].en);
      chk($sformatf("vec%0d_cnt_clr", i), 0, i, m_clr, tbl[i].clr);
      chk($sformatf("vec%0d_done_at", i), 0, i, m_done[0], tbl[i].d1);
      chk($sformatf("vec%0d_done_at", i), 1, i, m_done[1], tbl[i].d0);
      chk($sformatf("vec%0d_aborted", i), 0, i, m_ab, tbl[i].ab);
      $display("vector %0d len_m1=%0d epochs_m1=%0d beats=%0d done_at=%0d/%0d", i,
               tbl[i].lm, tbl[i].em, m_v, m_done[0], m_done[1]);
    end

    // Reset in the middle of a job.
    @(posedge clk); #1;
    start_valid = 1; cfg_len_m1 = 4'd1; cfg_epochs_m1 = 8'd5;
    @(posedge clk); #1 start_valid = 0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_state("async_rst");
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rst_no_done", 0, c, int'(o_done[0]), 0);
      chk("rst_no_done", 1, c, int'(o_done[1]), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    prev_epoch = 0;
    clear_stim();
    run_window(5, 2, 0);
    $display("after reset job beats=%0d done_at=%0d/%0d", m_v, m_done[0], m_done[1]);

    // Randomised jobs with halts, late/early aborts and start_valid noise.
    for (int r = 0; r < 25; r++) begin
      clear_stim();
      lm = $urandom_range(0, 15);
      em = $urandom_range(0, 3);
      total = (lm + 1) * (em + 1);
      for (int c = 2; c < total + 8; c++) s_halt[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) s_abort[$urandom_range(1, total + 6)] = 1;
      run_window(lm, em, $urandom_range(0, 1) == 1);
      $display("random %0d len_m1=%0d epochs_m1=%0d beats=%0d done_at=%0d/%0d aborted=%0d",
               r, lm, em, m_v, m_done[0], m_done[1], m_ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
